// File: rtl/datapath_types_pkg.sv
// Shared datapath types for the branch target buffer.
// Counter encoding, table entry layout and tag helper.
package datapath_types_pkg;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } cnt_e;

  // Widest tag for any legal index width; narrower tags are
  // stored zero-extended so the upper bits trim away.
  localparam int unsigned TAG_MAX_W = 30;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [31:0]          target;
    cnt_e                 cnt;
  } btb_entry_t;

  localparam btb_entry_t BTB_RST = '{
    valid:  1'b0,
    tag:    '0,
    target: '0,
    cnt:    WEAK_NT
  };

  // Tag is everything above the index and byte offset.
  function automatic logic [TAG_MAX_W-1:0] tag_of(
    input logic [31:0] pc,
    input int unsigned idx_w
  );
    return TAG_MAX_W'(pc >> (idx_w + 2));
  endfunction

endpackage

// File: rtl/branch_predictor_sat_cnt2.sv
// Two-bit saturating counter next-state logic.
// Purely combinational; holds at either end.
module sat_cnt2
  import datapath_types_pkg::*;
(
  input  cnt_e cnt,
  input  logic taken,
  output cnt_e cnt_next
);

  // Step toward the outcome unless already saturated.
  always_comb begin
    cnt_next = cnt;
    unique case (1'b1)
      taken && (cnt != STRONG_T):
        cnt_next = cnt_e'(cnt + 2'd1);
      !taken && (cnt != STRONG_NT):
        cnt_next = cnt_e'(cnt - 2'd1);
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit counters.
// Zero-latency lookup; one resolved-branch update per cycle.
module branch_predictor
  import datapath_types_pkg::*;
#(
  parameter int unsigned IDX_W = 3
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] iaddr,
  output logic        pred_control,
  output logic [31:0] pred_branch,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);

  localparam int unsigned N = 1 << IDX_W;

  btb_entry_t       tbl_q [N];
  btb_entry_t       l_ent;
  btb_entry_t       u_ent;
  btb_entry_t       entry_d;
  logic [IDX_W-1:0] l_idx;
  logic [IDX_W-1:0] u_idx;
  logic             l_hit;
  logic             u_hit;
  logic             wr_en;
  cnt_e             cnt_nxt;

  assign l_idx = iaddr[IDX_W+1:2];
  assign l_ent = tbl_q[l_idx];
  assign l_hit = l_ent.valid &&
                 (l_ent.tag == tag_of(iaddr, IDX_W));

  assign pred_control = l_hit && l_ent.cnt[1];
  assign pred_branch  = l_hit ? l_ent.target
                              : iaddr + 32'd4;

  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_ent = tbl_q[u_idx];
  assign u_hit = u_ent.valid &&
                 (u_ent.tag == tag_of(upd_pc, IDX_W));

  sat_cnt2 u_sat (
    .cnt      (u_ent.cnt),
    .taken    (upd_taken),
    .cnt_next (cnt_nxt)
  );

  // Train a hit, allocate on a taken miss, else leave alone.
  always_comb begin
    entry_d = u_ent;
    wr_en   = 1'b0;
    unique case (1'b1)
      upd_en && u_hit: begin
        wr_en       = 1'b1;
        entry_d.cnt = cnt_nxt;
        if (upd_taken) entry_d.target = upd_target;
      end
      upd_en && !u_hit && upd_taken: begin
        wr_en          = 1'b1;
        entry_d.valid  = 1'b1;
        entry_d.tag    = tag_of(upd_pc, IDX_W);
        entry_d.target = upd_target;
        entry_d.cnt    = WEAK_T;
      end
      default: ;
    endcase
  end

  // Flop table; reset wipes every entry, dropping any update.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < int'(N); i++) begin
        tbl_q[i] <= BTB_RST;
      end
    end else if (wr_en) begin
      tbl_q[u_idx] <= entry_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table,
// reset corner sequence, then random vs reference model.
module tb_branch_predictor;

  logic        CLK;
  logic        nRST;
  logic [31:0] iaddr;
  logic        pred_control;
  logic [31:0] pred_branch;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;

  int n_cmp = 0;
  int n_bad = 0;

  branch_predictor #(.IDX_W(3)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .iaddr        (iaddr),
    .pred_control (pred_control),
    .pred_branch  (pred_branch),
    .upd_en       (upd_en),
    .upd_pc       (upd_pc),
    .upd_taken    (upd_taken),
    .upd_target   (upd_target)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        ue;
    logic [31:0] up;
    logic        ut;
    logic [31:0] tg;
    logic [31:0] ia;
    logic        ec;
    logic [31:0] eb;
  } vec_t;

  vec_t vq[$];

  // Reference model: 8 entries, tag = pc >> 5.
  bit          m_v   [8];
  int unsigned m_tag [8];
  logic [31:0] m_tgt [8];
  int          m_cnt [8];

  function automatic void m_reset();
    for (int i = 0; i < 8; i++) begin
      m_v[i]   = 1'b0;
      m_tag[i] = 0;
      m_tgt[i] = 32'h0;
      m_cnt[i] = 1;
    end
  endfunction

  function automatic void m_look(
    input  logic [31:0] a,
    output logic        c,
    output logic [31:0] b
  );
    int  i;
    bit  h;
    i = int'((a >> 2) % 8);
    h = m_v[i] && (m_tag[i] == (a >> 5));
    c = h && (m_cnt[i] >= 2);
    b = h ? m_tgt[i] : a + 32'd4;
  endfunction

  function automatic void m_upd(
    input logic [31:0] pc,
    input logic        t,
    input logic [31:0] tg
  );
    int i;
    i = int'((pc >> 2) % 8);
    if (m_v[i] && (m_tag[i] == (pc >> 5))) begin
      if (t) begin
        m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
        m_tgt[i] = tg;
      end else begin
        m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
      end
    end else if (t) begin
      m_v[i]   = 1'b1;
      m_tag[i] = pc >> 5;
      m_tgt[i] = tg;
      m_cnt[i] = 2;
    end
  endfunction

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(
    input logic        ue,
    input logic [31:0] up,
    input logic        ut,
    input logic [31:0] tg,
    input logic [31:0] ia
  );
    upd_en     = ue;
    upd_pc     = up;
    upd_taken  = ut;
    upd_target = tg;
    iaddr      = ia;
  endtask

  task automatic addv(
    input logic        ue,
    input logic [31:0] up,
    input logic        ut,
    input logic [31:0] tg,
    input logic [31:0] ia,
    input logic        ec,
    input logic [31:0] eb
  );
    vq.push_back('{ue, up, ut, tg, ia, ec, eb});
  endtask

  logic        ec;
  logic [31:0] eb;
  logic [31:0] rpc;
  logic [31:0] ria;

  initial begin
    nRST = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h40);
    m_reset();

    // Lookups see pre-update state of the same cycle.
    addv(0, 32'h0,  0, 32'h0,   32'h40, 0, 32'h44);
    addv(1, 32'h40, 1, 32'h100, 32'h40, 0, 32'h44);
    addv(1, 32'h40, 0, 32'h0,   32'h40, 1, 32'h100);
    addv(1, 32'h40, 0, 32'h0,   32'h40, 0, 32'h100);
    addv(1, 32'h40, 1, 32'h100, 32'h40, 0, 32'h100);
    addv(0, 32'h0,  0, 32'h0,   32'h40, 0, 32'h100);
    addv(1, 32'h40, 1, 32'h100, 32'h40, 0, 32'h100);
    addv(1, 32'h40, 1, 32'h100, 32'h40, 1, 32'h100);
    addv(1, 32'h40, 1, 32'h100, 32'h40, 1, 32'h100);
    addv(1, 32'h40, 1, 32'h120, 32'h40, 1, 32'h100);
    addv(1, 32'h40, 0, 32'h0,   32'h40, 1, 32'h120);
    addv(0, 32'h0,  0, 32'h0,   32'h40, 1, 32'h120);
    addv(1, 32'h60, 1, 32'h200, 32'h60, 0, 32'h64);
    addv(0, 32'h0,  0, 32'h0,   32'h40, 0, 32'h44);
    addv(1, 32'h40, 0, 32'h0,   32'h60, 1, 32'h200);
    addv(0, 32'h0,  0, 32'h0,   32'h60, 1, 32'h200);
    addv(1, 32'h60, 0, 32'h0,   32'h60, 1, 32'h200);
    addv(0, 32'h0,  0, 32'h0,   32'h60, 0, 32'h200);
    addv(1, 32'h80, 1, 32'h300, 32'h80, 0, 32'h84);
    addv(0, 32'h0,  0, 32'h0,   32'h80, 1, 32'h300);
    addv(0, 32'h0,  0, 32'h0,   32'h83, 1, 32'h300);
    addv(0, 32'h0,  0, 32'h0,   32'h9C, 0, 32'hA0);

    // Reset state before release.
    #2;
    chk("rst_ctl", {31'h0, pred_control}, 32'h0);
    chk("rst_br",  pred_branch, 32'h44);
    iaddr = 32'hFFFF_FFF0;
    #1;
    chk("rst_br_hi", pred_branch, 32'hFFFF_FFF4);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    nRST = 1'b1;

    foreach (vq[k]) begin
      drive(vq[k].ue, vq[k].up, vq[k].ut, vq[k].tg, vq[k].ia);
      #3;
      chk($sformatf("v%0d_ctl", k), {31'h0, pred_control},
          {31'h0, vq[k].ec});
      chk($sformatf("v%0d_br", k), pred_branch, vq[k].eb);
      @(posedge CLK);
      #1;
    end

    // Async reset mid-update discards the write.
    drive(1'b1, 32'h44, 1'b1, 32'h500, 32'h80);
    #1;
    nRST = 1'b0;
    #1;
    chk("arst_ctl", {31'h0, pred_control}, 32'h0);
    chk("arst_br",  pred_branch, 32'h84);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h44);
    #2;
    chk("arst_44_ctl", {31'h0, pred_control}, 32'h0);
    chk("arst_44_br",  pred_branch, 32'h48);
    iaddr = 32'h60;
    #1;
    chk("arst_60_br", pred_branch, 32'h64);
    @(posedge CLK);
    #1;

    // Random traffic against the model.
    m_reset();
    for (int c = 0; c < 600; c++) begin
      rpc = ($urandom_range(0, 3) << 5) |
            ($urandom_range(0, 7) << 2) |
            $urandom_range(0, 3);
      ria = ($urandom_range(0, 3) << 5) |
            ($urandom_range(0, 7) << 2) |
            $urandom_range(0, 3);
      if ($urandom_range(0, 2) == 0) ria = rpc;
      drive($urandom_range(0, 9) < 7, rpc,
            $urandom_range(0, 2) != 0, $urandom, ria);
      if ($urandom_range(0, 59) == 0) begin
        nRST = 1'b0;
        m_reset();
        #1;
        m_look(ria, ec, eb);
        chk("rnd_rst_ctl", {31'h0, pred_control}, {31'h0, ec});
        chk("rnd_rst_br",  pred_branch, eb);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
      end else begin
        m_look(ria, ec, eb);
        #3;
        chk("rnd_ctl", {31'h0, pred_control}, {31'h0, ec});
        chk("rnd_br",  pred_branch, eb);
        @(posedge CLK);
        if (upd_en) m_upd(upd_pc, upd_taken, upd_target);
        #1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
